preg_alloc_ctrl: RTL

//  Sequences the free physical-register queue (free_preg_queue) for the rename stage.

---
 rtl/preg_alloc_if.sv | 88 ++++++++
 rtl/preg_alloc_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/preg_alloc_if.sv
// ---------------------------------------------------------------------------
// preg_alloc_if
//   Bundles the handshake and queue-side signals of the physical-register
//   allocation controller.
//
//   Handshake semantics (all channels):
//     A transfer happens on a rising clk edge where both valid and ready are
//     high. The source holds its payload stable while valid is high and ready
//     is low. The controller's ready depends combinationally on its own state
//     and on q_full, never on the source's valid.
//     - alloc: alloc_req plays the role of valid. alloc_gnt is the grant, and
//       alloc_pregs carries the payload in the same cycle.
//     - free : free_valid / free_ready, payload free_preg.
//     - rec  : rec_valid / rec_ready, payload rec_preg and rec_last.
//
//   Queue side: q_w_en pushes q_preg_in. q_r_en pops RW entries whose values
//   are already visible on q_preg_out (head entry in the LSBs).
//
//   Modports:
//     slave  - the controller (preg_alloc_ctrl)
//     master - the environment (rename, commit, ROB walk and the free queue)
// ---------------------------------------------------------------------------
interface preg_alloc_if #(
  parameter int PREG_W = 7,
  parameter int RW     = 2
);
  // rename allocation
  logic                 alloc_req;
  logic                 alloc_gnt;
  logic [PREG_W*RW-1:0] alloc_pregs;
  // commit frees
  logic                 free_valid;
  logic [PREG_W-1:0]    free_preg;
  logic                 free_ready;
  // flush recovery
  logic                 flush;
  logic                 rec_valid;
  logic [PREG_W-1:0]    rec_preg;
  logic                 rec_last;
  logic                 rec_ready;
  // free-preg queue
  logic                 q_w_en;
  logic [PREG_W-1:0]    q_preg_in;
  logic                 q_r_en;
  logic [PREG_W*RW-1:0] q_preg_out;
  logic                 q_full;
  logic                 q_empty;

  modport slave (
    input  alloc_req,
    output alloc_gnt,
    output alloc_pregs,
    input  free_valid,
    input  free_preg,
    output free_ready,
    input  flush,
    input  rec_valid,
    input  rec_preg,
    input  rec_last,
    output rec_ready,
    output q_w_en,
    output q_preg_in,
    output q_r_en,
    input  q_preg_out,
    input  q_full,
    input  q_empty
  );

  modport master (
    output alloc_req,
    input  alloc_gnt,
    input  alloc_pregs,
    output free_valid,
    output free_preg,
    input  free_ready,
    output flush,
    output rec_valid,
    output rec_preg,
    output rec_last,
    input  rec_ready,
    input  q_w_en,
    input  q_preg_in,
    input  q_r_en,
    output q_preg_out,
    output q_full,
    output q_empty
  );
endinterface

// File: rtl/preg_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// preg_alloc_ctrl
//   Sequences the free physical-register queue for the rename stage.
//   After reset it seeds the queue with pregs NUM_AREGS..NUM_PREGS-1, one
//   per cycle. It then grants RENAME_WIDTH pregs per cycle to rename. The
//   queue's single write port is shared between commit frees (RUN) and
//   flush-recovery reclaims (RECLAIM). A local occupancy count gates
//   grants, so q_empty is never used for gating.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   bus (slave)         alloc / free / reclaim handshakes and queue port
//   init_done           high in RUN or RECLAIM
//   free_count          local occupancy count of the queue
//   err                 sticky: a push was attempted at max occupancy
//   o_dbg_state         current FSM state (INIT=0, RUN=1, RECLAIM=2)
//   o_dbg_cnt_mismatch  queue reports empty while the local count is nonzero
// ---------------------------------------------------------------------------
module preg_alloc_ctrl #(
  parameter int NUM_PREGS    = 128,
  parameter int NUM_AREGS    = 32,
  parameter int RENAME_WIDTH = 2,
  parameter int PREG_W       = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              rst,
  preg_alloc_if.slave       bus,
  output logic              init_done,
  output logic [PREG_W:0]   free_count,
  output logic              err,
  output logic [1:0]        o_dbg_state,
  output logic              o_dbg_cnt_mismatch
);

  // FSM encoding
  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_RECLAIM = 2'd2;

  // The queue can never hold more than the non-architectural pregs.
  localparam logic [PREG_W:0]   MAX_OCC    = (PREG_W+1)'(NUM_PREGS - NUM_AREGS);
  localparam logic [PREG_W:0]   RW_CNT     = (PREG_W+1)'(RENAME_WIDTH);
  localparam logic [PREG_W:0]   CNT_ONE    = (PREG_W+1)'(1);
  localparam logic [PREG_W-1:0] SEED_FIRST = PREG_W'(NUM_AREGS);
  localparam logic [PREG_W-1:0] SEED_LAST  = PREG_W'(NUM_PREGS - 1);
  localparam logic [PREG_W-1:0] PTR_ONE    = PREG_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [PREG_W-1:0] r_init_ptr;
  logic [PREG_W:0]   r_free_count;
  logic              r_err;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic [1:0]        w_state_next;
  logic              w_push_req;   // some source wants the write port
  logic [PREG_W-1:0] w_push_data;
  logic              w_at_max;
  logic              w_push;       // push actually issued to the queue
  logic              w_drop;       // push attempt refused at max occupancy
  logic              w_gnt;
  logic              w_free_ready;
  logic              w_rec_ready;
  logic [PREG_W:0]   w_count_next;

  assign w_at_max = (r_free_count == MAX_OCC);

  // The reset term keeps the INIT push invisible while rst is held. Otherwise
  // the queue would see a seed write during reset.
  always_comb begin
    w_state_next = r_state;
    w_push_req   = 1'b0;
    w_push_data  = '0;
    w_gnt        = 1'b0;
    w_free_ready = 1'b0;
    w_rec_ready  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_INIT: begin
          // Seed one preg per cycle. Flush and alloc requests are ignored.
          w_push_req  = 1'b1;
          w_push_data = r_init_ptr;
          if (r_init_ptr == SEED_LAST) begin
            w_state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          w_free_ready = !bus.q_full;
          // A flush cancels this cycle's grant. A commit free in the same
          // cycle still goes through.
          w_gnt = bus.alloc_req && !bus.flush && (r_free_count >= RW_CNT);
          if (bus.free_valid && w_free_ready) begin
            w_push_req  = 1'b1;
            w_push_data = bus.free_preg;
          end
          if (bus.flush) begin
            w_state_next = ST_RECLAIM;
          end
        end
        ST_RECLAIM: begin
          // Only the ROB walk may write. Further flush pulses have no effect.
          w_rec_ready = !bus.q_full;
          if (bus.rec_valid && w_rec_ready) begin
            w_push_req  = 1'b1;
            w_push_data = bus.rec_preg;
            if (bus.rec_last) begin
              w_state_next = ST_RUN;
            end
          end
        end
        default: begin
          w_state_next = ST_INIT;
        end
      endcase
    end
  end

  // A push at max occupancy is still acknowledged upstream through ready.
  // The queue write is suppressed and err latches the overflow.
  assign w_push = w_push_req && !w_at_max;
  assign w_drop = w_push_req && w_at_max;

  // Push and pop in the same cycle are both counted.
  assign w_count_next = r_free_count
                      + (w_push ? CNT_ONE : '0)
                      - (w_gnt  ? RW_CNT  : '0);

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_init_ptr   <= SEED_FIRST;
      r_free_count <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_free_count <= w_count_next;
      if (r_state == ST_INIT) begin
        r_init_ptr <= r_init_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.alloc_gnt   = w_gnt;
  // The queue head is read with zero latency. While rst is held this output
  // is forced to zero like every other output.
  assign bus.alloc_pregs = rst ? '0 : bus.q_preg_out;
  assign bus.free_ready  = w_free_ready;
  assign bus.rec_ready   = w_rec_ready;
  assign bus.q_w_en      = w_push;
  assign bus.q_preg_in   = w_push_data;
  assign bus.q_r_en      = w_gnt;

  assign init_done  = (r_state == ST_RUN) || (r_state == ST_RECLAIM);
  assign free_count = r_free_count;
  assign err        = r_err;

  assign o_dbg_state        = r_state;
  // The queue shares rst and updates on the same edges, so its empty flag
  // must agree with a zero local count.
  assign o_dbg_cnt_mismatch = bus.q_empty && (r_free_count != '0);

endmodule
